com_regbank: RTL



---
 rtl/com_regbank_if.sv | 16 +
 rtl/com_regbank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/com_regbank_if.sv
// Host-side UART pins and fabric register bus for com_regbank.
interface com_regbank_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 8
);
  logic                 rx;
  logic                 tx;
  logic [NREG*DW-1:0]   wr_data;
  logic [NREG-1:0]      wr_stb;
  logic [NREG*DW-1:0]   rd_data;
  logic                 busy;
  logic                 err;

  modport master (output rx, rd_data, input tx, wr_data, wr_stb, busy, err);
  modport slave  (input rx, rd_data, output tx, wr_data, wr_stb, busy, err);
endinterface

// File: rtl/com_regbank.sv
// UART-accessed register bank: write/read command frames, ACK/NAK responses,
// inter-byte timeout and framing-error recovery.
module com_regbank #(
  parameter int unsigned BAUD_DIV = 104,
  parameter int unsigned NREG     = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned TIMEOUT  = 20,
  parameter logic [DW-1:0] INIT   = '0
) (
  input  logic clk,
  input  logic rst_n,
  com_regbank_if.slave bus
);
  localparam int unsigned NB      = DW / 8;
  localparam int unsigned CW      = $clog2(BAUD_DIV + 1);
  localparam int unsigned TO_CLKS = TIMEOUT * BAUD_DIV;
  localparam int unsigned TW      = $clog2(TO_CLKS + 1);
  localparam int unsigned BW      = 3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [1:0] {F_IDLE, F_WDATA, F_RESP} f_st_e;

  logic               rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_e             rx_st_q, rx_st_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic               rx_byte_c, rx_ferr_c;

  f_st_e              f_st_q, f_st_d;
  logic [6:0]         addr_q, addr_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [DW-1:0]      stage_q, stage_d;
  logic [TW-1:0]      to_q, to_d;
  logic [DW-1:0]      resp_q, resp_d;
  logic [BW-1:0]      rn_q, rn_d;
  logic [3:0]         tbit_q, tbit_d;
  logic [CW-1:0]      tcnt_q, tcnt_d;
  logic               tx_q, tx_d, busy_q, busy_d, err_q, err_d;
  logic [NREG*DW-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]    wr_stb_q, wr_stb_d;

  logic [DW-1:0]      rd_sel_c;
  logic               cmd_ok_c, wr_ok_c;

  // Register selected by the command byte currently in the receive shifter.
  always_comb begin
    rd_sel_c = '0;
    for (int k = 0; k < NREG; k++) begin
      if (rx_sh_q[6:0] == 7'(k)) rd_sel_c = bus.rd_data[k*DW +: DW];
    end
  end

  assign cmd_ok_c = {1'b0, rx_sh_q[6:0]} < 8'(NREG);
  assign wr_ok_c  = {1'b0, addr_q} < 8'(NREG);

  // UART receiver: start re-check at half bit, data and stop at mid-bit.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q + CW'(1);
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_c = 1'b0;
    rx_ferr_c = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == CW'(BAUD_DIV/2 - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
          rx_cnt_d  = '0;
          rx_st_d   = RX_IDLE;
          rx_byte_c = rx_s2_q;
          rx_ferr_c = !rx_s2_q;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Frame parser, register update and response serialiser.
  always_comb begin
    logic [7:0] tx_byte;
    f_st_d    = f_st_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    stage_d   = stage_q;
    to_d      = '0;
    resp_d    = resp_q;
    rn_d      = rn_q;
    tbit_d    = tbit_q;
    tcnt_d    = tcnt_q;
    err_d     = 1'b0;
    wr_data_d = wr_data_q;
    wr_stb_d  = '0;
    unique case (f_st_q)
      F_IDLE: begin
        tbit_d = '0;
        tcnt_d = '0;
        if (rx_byte_c) begin
          addr_d = rx_sh_q[6:0];
          if (rx_sh_q[7]) begin
            f_st_d = F_WDATA;
            bcnt_d = BW'(NB);
          end else begin
            f_st_d = F_RESP;
            if (cmd_ok_c) begin
              resp_d = rd_sel_c;
              rn_d   = BW'(NB);
            end else begin
              resp_d = DW'(8'h15) << (DW - 8);
              rn_d   = BW'(1);
              err_d  = 1'b1;
            end
          end
        end
      end
      F_WDATA: begin
        to_d = to_q + TW'(1);
        if (rx_byte_c) begin
          to_d    = '0;
          stage_d = DW'({stage_q, rx_sh_q});
          bcnt_d  = bcnt_q - BW'(1);
          if (bcnt_q == BW'(1)) begin
            f_st_d = F_RESP;
            rn_d   = BW'(1);
            if (wr_ok_c) begin
              for (int k = 0; k < NREG; k++) begin
                if (addr_q == 7'(k)) begin
                  wr_data_d[k*DW +: DW] = DW'({stage_q, rx_sh_q});
                  wr_stb_d[k]           = 1'b1;
                end
              end
              resp_d = DW'(8'h06) << (DW - 8);
            end else begin
              resp_d = DW'(8'h15) << (DW - 8);
              err_d  = 1'b1;
            end
          end
        end else if (to_q == TW'(TO_CLKS - 1)) begin
          err_d  = 1'b1;
          f_st_d = F_IDLE;
        end
      end
      F_RESP: begin
        tcnt_d = tcnt_q + CW'(1);
        if (tcnt_q == CW'(BAUD_DIV - 1)) begin
          tcnt_d = '0;
          tbit_d = tbit_q + 4'd1;
          if (tbit_q == 4'd9) begin
            tbit_d = '0;
            if (rn_q == BW'(1)) begin
              f_st_d = F_IDLE;
            end else begin
              rn_d   = rn_q - BW'(1);
              resp_d = resp_q << 8;
            end
          end
        end
      end
      default: f_st_d = F_IDLE;
    endcase
    if (rx_ferr_c) begin
      err_d  = 1'b1;
      f_st_d = F_IDLE;
    end
    busy_d  = (f_st_d != F_IDLE);
    // TX follows the next-state bit index so it stays aligned with BUSY.
    tx_byte = resp_d[DW-1 -: 8];
    tx_d    = 1'b1;
    if (f_st_d == F_RESP) begin
      unique case (tbit_d)
        4'd0:    tx_d = 1'b0;
        4'd9:    tx_d = 1'b1;
        default: tx_d = tx_byte[3'(tbit_d - 4'd1)];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      f_st_q    <= F_IDLE;
      addr_q    <= '0;
      bcnt_q    <= '0;
      stage_q   <= '0;
      to_q      <= '0;
      resp_q    <= '0;
      rn_q      <= '0;
      tbit_q    <= '0;
      tcnt_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_data_q <= {NREG{INIT}};
      wr_stb_q  <= '0;
    end else begin
      rx_s1_q   <= bus.rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      f_st_q    <= f_st_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      stage_q   <= stage_d;
      to_q      <= to_d;
      resp_q    <= resp_d;
      rn_q      <= rn_d;
      tbit_q    <= tbit_d;
      tcnt_q    <= tcnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
endmodule
